// File: rtl/tx_arbiter_if.sv
// -----------------------------------------------------------------------------
// tx_arbiter_if
// Bundles the requester-side and txshift-side signals of tx_arbiter.
//   i_Req_Valid / i_Req_Data / i_Req_Baud : per-requester request, byte, divisor
//   o_Req_Ack / o_Req_Err                 : per-requester completion / abort pulse
//   o_Busy                                : arbiter not idle
//   o_Tx_Enable / o_Tx_Data / o_Tx_Baud   : drive txshift i_Enable/i_Pwdata/i_Baud
//   i_Tx_Ready                            : txshift o_Pready (frame done)
// Modports: slave = the arbiter's view, master = the surrounding system's view.
// -----------------------------------------------------------------------------
interface tx_arbiter_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]   i_Req_Valid;
  logic [8*N_REQ-1:0] i_Req_Data;
  logic [8*N_REQ-1:0] i_Req_Baud;
  logic [N_REQ-1:0]   o_Req_Ack;
  logic [N_REQ-1:0]   o_Req_Err;
  logic               o_Busy;
  logic               o_Tx_Enable;
  logic [7:0]         o_Tx_Data;
  logic [7:0]         o_Tx_Baud;
  logic               i_Tx_Ready;

  modport slave (
    input  i_Req_Valid, i_Req_Data, i_Req_Baud, i_Tx_Ready,
    output o_Req_Ack, o_Req_Err, o_Busy, o_Tx_Enable, o_Tx_Data, o_Tx_Baud
  );

  modport master (
    output i_Req_Valid, i_Req_Data, i_Req_Baud, i_Tx_Ready,
    input  o_Req_Ack, o_Req_Err, o_Busy, o_Tx_Enable, o_Tx_Data, o_Tx_Baud
  );
endinterface

// File: rtl/tx_arbiter.sv
// -----------------------------------------------------------------------------
// tx_arbiter
// Round-robin scheduler sharing one txshift UART transmit shifter between
// N_REQ byte requesters. A granted requester's byte and baud divisor are
// latched and held on o_Tx_Data/o_Tx_Baud; o_Tx_Enable is raised after one
// settle cycle and dropped on the first 0->1 edge of i_Tx_Ready, at which
// point the requester receives a one-cycle ack. GAP_CYCLES idle cycles follow
// every frame before the next arbitration.
//
// Ports:
//   i_Pclk      system clock (rising edge)
//   i_Presetn   asynchronous active-low reset
//   bus         tx_arbiter_if.slave (requester and txshift signals)
//
// Optional feature: define TX_ARBITER_TIMEOUT_EN to abort a frame after
// TIMEOUT_CYCLES cycles in SEND without a Ready edge (pulses o_Req_Err).
// Without the macro o_Req_Err is tied low and SEND waits indefinitely.
// -----------------------------------------------------------------------------
module tx_arbiter #(
  parameter int N_REQ          = 4,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 20000
) (
  input logic          i_Pclk,
  input logic          i_Presetn,
  tx_arbiter_if.slave  bus
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);

  if (N_REQ < 2 || N_REQ > 8 || GAP_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("tx_arbiter: parameter out of range");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SEND,
    ST_GAP
  } state_t;

  state_t             state;
  logic [PTR_W-1:0]   ptr;
  logic [PTR_W-1:0]   grant;
  logic [PTR_W-1:0]   sel;
  logic [GAP_W-1:0]   gap_cnt;
  logic               ready_q;
  logic               ready_rise;
  logic               any_valid;
  logic [N_REQ-1:0]   grant_onehot;
  logic [N_REQ-1:0]   ack_r;
  logic               tx_en_r;
  logic [7:0]         tx_data_r;
  logic [7:0]         tx_baud_r;

  assign any_valid    = |bus.i_Req_Valid;
  assign ready_rise   = bus.i_Tx_Ready & ~ready_q;
  assign grant_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << grant;

  // Round-robin search starting just after the last grant. Scanning from the
  // farthest candidate back to the nearest lets the nearest one win.
  always_comb begin
    sel = ptr;
    for (int i = N_REQ; i >= 1; i--) begin
      if (bus.i_Req_Valid[PTR_W'((int'(ptr) + i) % N_REQ)]) begin
        sel = PTR_W'((int'(ptr) + i) % N_REQ);
      end
    end
  end

`ifdef TX_ARBITER_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0]  to_cnt;
  logic [TO_W-1:0]  to_nxt;
  logic [N_REQ-1:0] err_r;

  assign to_nxt        = to_cnt + 1'b1;
  assign bus.o_Req_Err = err_r;
`else
  assign bus.o_Req_Err = {N_REQ{1'b0}};
`endif

  always_ff @(posedge i_Pclk or negedge i_Presetn) begin
    if (!i_Presetn) begin
      state     <= ST_IDLE;
      ptr       <= PTR_W'(N_REQ - 1);
      grant     <= '0;
      gap_cnt   <= '0;
      ready_q   <= 1'b0;
      ack_r     <= '0;
      tx_en_r   <= 1'b0;
      tx_data_r <= '0;
      tx_baud_r <= '0;
`ifdef TX_ARBITER_TIMEOUT_EN
      to_cnt    <= '0;
      err_r     <= '0;
`endif
    end else begin
      ready_q <= bus.i_Tx_Ready;
      ack_r   <= '0;
`ifdef TX_ARBITER_TIMEOUT_EN
      err_r   <= '0;
`endif
      case (state)
        ST_IDLE: begin
          if (any_valid) begin
            grant     <= sel;
            ptr       <= sel;
            tx_data_r <= bus.i_Req_Data[{sel, 3'b000} +: 8];
            tx_baud_r <= bus.i_Req_Baud[{sel, 3'b000} +: 8];
            state     <= ST_LOAD;
          end
        end
        // Data/baud already stable at txshift; enable comes up now.
        ST_LOAD: begin
          tx_en_r <= 1'b1;
          state   <= ST_SEND;
`ifdef TX_ARBITER_TIMEOUT_EN
          to_cnt  <= '0;
`endif
        end
        ST_SEND: begin
          // A Ready edge takes precedence over a coincident timeout.
          if (ready_rise) begin
            tx_en_r <= 1'b0;
            ack_r   <= grant_onehot;
            gap_cnt <= GAP_W'(GAP_CYCLES);
            state   <= ST_GAP;
          end
`ifdef TX_ARBITER_TIMEOUT_EN
          else if (to_nxt == TO_W'(TIMEOUT_CYCLES)) begin
            tx_en_r <= 1'b0;
            err_r   <= grant_onehot;
            gap_cnt <= GAP_W'(GAP_CYCLES);
            state   <= ST_GAP;
          end else begin
            to_cnt  <= to_nxt;
          end
`endif
        end
        ST_GAP: begin
          if (gap_cnt <= GAP_W'(1)) begin
            state <= ST_IDLE;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.o_Req_Ack   = ack_r;
  assign bus.o_Busy      = (state != ST_IDLE);
  assign bus.o_Tx_Enable = tx_en_r;
  assign bus.o_Tx_Data   = tx_data_r;
  assign bus.o_Tx_Baud   = tx_baud_r;

endmodule

// File: tb/tb_tx_arbiter.sv
`timescale 1ns/1ps
module tb_tx_arbiter;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  tx_arbiter_if #(.N_REQ(4)) bus ();

  tx_arbiter #(
    .N_REQ(4),
    .GAP_CYCLES(2),
    .TIMEOUT_CYCLES(50)
  ) dut (
    .i_Pclk(clk),
    .i_Presetn(rstn),
    .bus(bus)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    rstn = 1'b0;
    bus.i_Req_Valid = '0;
    bus.i_Tx_Ready  = 1'b0;
    repeat (2) tick();
    rstn = 1'b1;
    tick();
  endtask

  // Advances until o_Tx_Enable is high; lows = number of cycles waited.
  task automatic wait_en(output int lows);
    lows = 0;
    while (bus.o_Tx_Enable !== 1'b1 && lows < 200) begin
      tick();
      lows++;
    end
  endtask

  task automatic pulse_ready;
    bus.i_Tx_Ready = 1'b1;
    tick();
    bus.i_Tx_Ready = 1'b0;
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    bus.i_Req_Valid = 4'b1111;
    bus.i_Tx_Ready  = 1'b0;
    bus.i_Req_Data  = {8'h13, 8'h12, 8'h11, 8'h10};
    bus.i_Req_Baud  = {8'd4, 8'd3, 8'd2, 8'd1};
    repeat (3) tick();
    checks++; if (bus.o_Tx_Enable !== 1'b0) begin errors++; $display("FAIL reset_en: got %b want 0", bus.o_Tx_Enable); end
    checks++; if (bus.o_Busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.o_Busy); end
    checks++; if (bus.o_Req_Ack !== 4'b0000) begin errors++; $display("FAIL reset_ack: got %b want 0000", bus.o_Req_Ack); end
    checks++; if (bus.o_Req_Err !== 4'b0000) begin errors++; $display("FAIL reset_err: got %b want 0000", bus.o_Req_Err); end
    checks++; if (bus.o_Tx_Data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", bus.o_Tx_Data); end
    checks++; if (bus.o_Tx_Baud !== 8'h00) begin errors++; $display("FAIL reset_baud: got %h want 00", bus.o_Tx_Baud); end
    bus.i_Req_Valid = '0;
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_single;
    int lows;
    apply_reset();
    bus.i_Req_Data  = {8'h00, 8'h00, 8'h00, 8'h51};
    bus.i_Req_Baud  = {8'd0, 8'd0, 8'd0, 8'd87};
    bus.i_Req_Valid = 4'b0001;
    tick();
    checks++; if (bus.o_Busy !== 1'b1 || bus.o_Tx_Enable !== 1'b0) begin errors++; $display("FAIL single_load: busy=%b en=%b want busy=1 en=0", bus.o_Busy, bus.o_Tx_Enable); end
    checks++; if (bus.o_Tx_Data !== 8'h51 || bus.o_Tx_Baud !== 8'd87) begin errors++; $display("FAIL single_latch: data=%h baud=%0d want 51/87", bus.o_Tx_Data, bus.o_Tx_Baud); end
    wait_en(lows);
    checks++; if (lows !== 1) begin errors++; $display("FAIL single_latency: got %0d more cycles want 1", lows); end
    pulse_ready();
    checks++; if (bus.o_Req_Ack !== 4'b0001 || bus.o_Tx_Enable !== 1'b0) begin errors++; $display("FAIL single_ack: ack=%b en=%b want 0001/0", bus.o_Req_Ack, bus.o_Tx_Enable); end
    tick();
    checks++; if (bus.o_Req_Ack !== 4'b0000) begin errors++; $display("FAIL single_ack_pulse: got %b want 0000", bus.o_Req_Ack); end
    // valid still high: the same requester is granted again
    wait_en(lows);
    checks++; if (lows !== 3 || bus.o_Tx_Data !== 8'h51) begin errors++; $display("FAIL single_regrant: wait=%0d data=%h want 3/51", lows, bus.o_Tx_Data); end
    pulse_ready();
    checks++; if (bus.o_Req_Ack !== 4'b0001) begin errors++; $display("FAIL single_ack2: got %b want 0001", bus.o_Req_Ack); end
    bus.i_Req_Valid = '0;
    repeat (2) tick();
    checks++; if (bus.o_Busy !== 1'b0) begin errors++; $display("FAIL single_idle: busy=%b want 0", bus.o_Busy); end
  endtask

  task automatic test_round_robin;
    int lows;
    int acks;
    logic [3:0] exp;
    apply_reset();
    acks = 0;
    bus.i_Req_Data  = {8'h13, 8'h12, 8'h11, 8'h10};
    bus.i_Req_Baud  = {8'd40, 8'd30, 8'd20, 8'd10};
    bus.i_Req_Valid = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      wait_en(lows);
      checks++; if (lows !== ((k == 0) ? 2 : 4)) begin errors++; $display("FAIL rr_gap%0d: low cycles=%0d want %0d", k, lows, (k == 0) ? 2 : 4); end
      checks++; if (bus.o_Tx_Data !== 8'h10 + 8'(k)) begin errors++; $display("FAIL rr_order%0d: data=%h want %h", k, bus.o_Tx_Data, 8'h10 + 8'(k)); end
      pulse_ready();
      exp = 4'b0001 << k;
      if (bus.o_Req_Ack !== 4'b0000) acks++;
      checks++; if (bus.o_Req_Ack !== exp) begin errors++; $display("FAIL rr_ack%0d: got %b want %b", k, bus.o_Req_Ack, exp); end
      if (k != 2) bus.i_Req_Valid[k] = 1'b0;
    end
    checks++; if (acks !== 4) begin errors++; $display("FAIL rr_ack_count: got %0d want 4", acks); end
    wait_en(lows);
    checks++; if (bus.o_Tx_Data !== 8'h12 || bus.o_Tx_Baud !== 8'd30) begin errors++; $display("FAIL rr_wrap: data=%h baud=%0d want 12/30", bus.o_Tx_Data, bus.o_Tx_Baud); end
    pulse_ready();
    checks++; if (bus.o_Req_Ack !== 4'b0100) begin errors++; $display("FAIL rr_wrap_ack: got %b want 0100", bus.o_Req_Ack); end
    bus.i_Req_Valid = '0;
    repeat (3) tick();
  endtask

  task automatic test_priority;
    int lows;
    apply_reset();
    bus.i_Req_Data  = {8'h63, 8'h00, 8'h61, 8'h00};
    bus.i_Req_Valid = 4'b0010;
    wait_en(lows);
    checks++; if (bus.o_Tx_Data !== 8'h61) begin errors++; $display("FAIL prio_first: data=%h want 61", bus.o_Tx_Data); end
    pulse_ready();
    checks++; if (bus.o_Req_Ack !== 4'b0010) begin errors++; $display("FAIL prio_ack1: got %b want 0010", bus.o_Req_Ack); end
    bus.i_Req_Valid = 4'b1010;
    wait_en(lows);
    checks++; if (bus.o_Tx_Data !== 8'h63) begin errors++; $display("FAIL prio_3_before_1: data=%h want 63", bus.o_Tx_Data); end
    pulse_ready();
    checks++; if (bus.o_Req_Ack !== 4'b1000) begin errors++; $display("FAIL prio_ack3: got %b want 1000", bus.o_Req_Ack); end
    bus.i_Req_Valid = 4'b0010;
    wait_en(lows);
    checks++; if (bus.o_Tx_Data !== 8'h61) begin errors++; $display("FAIL prio_then_1: data=%h want 61", bus.o_Tx_Data); end
    pulse_ready();
    bus.i_Req_Valid = '0;
    repeat (3) tick();
  endtask

  task automatic test_drop_valid;
    int lows;
    apply_reset();
    bus.i_Req_Data  = {8'h00, 8'hA5, 8'h00, 8'h00};
    bus.i_Req_Baud  = {8'd0, 8'h30, 8'd0, 8'd0};
    bus.i_Req_Valid = 4'b0100;
    wait_en(lows);
    checks++; if (bus.o_Tx_Data !== 8'hA5 || bus.o_Tx_Baud !== 8'h30) begin errors++; $display("FAIL drop_latch: data=%h baud=%h want A5/30", bus.o_Tx_Data, bus.o_Tx_Baud); end
    bus.i_Req_Valid = '0;
    repeat (3) tick();
    checks++; if (bus.o_Tx_Enable !== 1'b1) begin errors++; $display("FAIL drop_en_held: en=%b want 1", bus.o_Tx_Enable); end
    pulse_ready();
    checks++; if (bus.o_Req_Ack !== 4'b0100) begin errors++; $display("FAIL drop_ack: got %b want 0100", bus.o_Req_Ack); end
    repeat (2) tick();
    checks++; if (bus.o_Busy !== 1'b0) begin errors++; $display("FAIL drop_idle: busy=%b want 0", bus.o_Busy); end
    tick();
    checks++; if (bus.o_Tx_Enable !== 1'b0 || bus.o_Busy !== 1'b0) begin errors++; $display("FAIL drop_stay_idle: en=%b busy=%b want 0/0", bus.o_Tx_Enable, bus.o_Busy); end
  endtask

  task automatic test_reset_mid;
    int lows;
    apply_reset();
    bus.i_Req_Data  = {8'h00, 8'h00, 8'h00, 8'h51};
    bus.i_Req_Baud  = {8'd0, 8'd0, 8'd0, 8'd87};
    bus.i_Req_Valid = 4'b0001;
    wait_en(lows);
    repeat (3) tick();
    rstn = 1'b0;
    #1;
    checks++; if (bus.o_Tx_Enable !== 1'b0 || bus.o_Busy !== 1'b0) begin errors++; $display("FAIL midrst_async: en=%b busy=%b want 0/0", bus.o_Tx_Enable, bus.o_Busy); end
    checks++; if (bus.o_Tx_Data !== 8'h00 || bus.o_Req_Ack !== 4'b0000) begin errors++; $display("FAIL midrst_clear: data=%h ack=%b want 00/0000", bus.o_Tx_Data, bus.o_Req_Ack); end
    bus.i_Tx_Ready = 1'b1;
    repeat (2) tick();
    bus.i_Tx_Ready = 1'b0;
    checks++; if (bus.o_Req_Ack !== 4'b0000) begin errors++; $display("FAIL midrst_noack: got %b want 0000", bus.o_Req_Ack); end
    tick();
    rstn = 1'b1;
    wait_en(lows);
    checks++; if (lows !== 2 || bus.o_Tx_Data !== 8'h51) begin errors++; $display("FAIL midrst_regrant: wait=%0d data=%h want 2/51", lows, bus.o_Tx_Data); end
    pulse_ready();
    checks++; if (bus.o_Req_Ack !== 4'b0001) begin errors++; $display("FAIL midrst_ack: got %b want 0001", bus.o_Req_Ack); end
    bus.i_Req_Valid = '0;
    repeat (3) tick();
  endtask

  task automatic test_timeout;
    int lows;
    apply_reset();
    bus.i_Req_Data  = {8'h00, 8'h00, 8'h00, 8'h77};
    bus.i_Req_Valid = 4'b0001;
    wait_en(lows);
`ifdef TX_ARBITER_TIMEOUT_EN
    repeat (49) tick();
    checks++; if (bus.o_Tx_Enable !== 1'b1 || bus.o_Req_Err !== 4'b0000) begin errors++; $display("FAIL to_early: en=%b err=%b want 1/0000", bus.o_Tx_Enable, bus.o_Req_Err); end
    tick();
    checks++; if (bus.o_Req_Err !== 4'b0001 || bus.o_Req_Ack !== 4'b0000 || bus.o_Tx_Enable !== 1'b0) begin errors++; $display("FAIL to_abort: err=%b ack=%b en=%b want 0001/0000/0", bus.o_Req_Err, bus.o_Req_Ack, bus.o_Tx_Enable); end
    bus.i_Req_Valid = '0;
    tick();
    checks++; if (bus.o_Req_Err !== 4'b0000) begin errors++; $display("FAIL to_pulse: err=%b want 0000", bus.o_Req_Err); end
`else
    repeat (60) tick();
    checks++; if (bus.o_Tx_Enable !== 1'b1 || bus.o_Req_Err !== 4'b0000) begin errors++; $display("FAIL to_wait: en=%b err=%b want 1/0000", bus.o_Tx_Enable, bus.o_Req_Err); end
    pulse_ready();
    checks++; if (bus.o_Req_Ack !== 4'b0001 || bus.o_Req_Err !== 4'b0000) begin errors++; $display("FAIL to_late_ack: ack=%b err=%b want 0001/0000", bus.o_Req_Ack, bus.o_Req_Err); end
    bus.i_Req_Valid = '0;
`endif
    repeat (3) tick();
  endtask

  initial begin
    bus.i_Req_Valid = '0;
    bus.i_Req_Data  = '0;
    bus.i_Req_Baud  = '0;
    bus.i_Tx_Ready  = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_priority();
    test_drop_valid();
    test_reset_mid();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
